// File: rtl/eg_pkg.sv
// Shared types and helpers for the Exp-Golomb serial encoder.
// Values are 4-bit unsigned; the prefix length n never exceeds 3.
package eg_pkg;

    localparam int MAX_PREFIX = 3;
    localparam int VAL_W      = 4;
    localparam int CNT_W      = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_SEP,
        S_OFFSET,
        S_GAP
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] n;
        logic [VAL_W-1:0] offset;
    } code_t;

    // n is the position of the leading one of v+1; offset is v+1 with that bit cleared.
    function automatic code_t eg_code(input logic [VAL_W-1:0] v);
        logic [VAL_W-1:0] vp1;
        code_t            c;
        vp1      = v + 1'b1;
        c.n      = '0;
        for (int i = 1; i <= MAX_PREFIX; i++) begin
            if (vp1[i]) c.n = CNT_W'(i);
        end
        c.offset = vp1 & ~(VAL_W'(1) << c.n);
        return c;
    endfunction

endpackage

// File: rtl/eg_fifo.sv
// Synchronous FIFO buffering values ahead of the encoder FSM.
// Pushes into an empty FIFO are never bypassed to the read side.
module eg_fifo
    import eg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = VAL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eg_encoder.sv
// Exp-Golomb serial encoder: buffers 4-bit values and emits one codeword per
// value MSB-first, followed by a fixed idle gap for the downstream decoder.
module eg_encoder
    import eg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_valid,
    input  logic [VAL_W-1:0] pi_data,
    output logic             pi_ready,
    output logic             so_data,
    output logic             so_valid,
    output logic             busy,
    output logic             err
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [VAL_W-1:0]       head;
    logic [$clog2(DEPTH):0] count;
    code_t                  head_code;

    state_t           state;
    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] bit_cnt;
    logic [VAL_W-1:0] off_r;
    logic [GW-1:0]    gap_cnt;

    assign pi_ready  = !full;
    assign push      = pi_valid && pi_ready && (pi_data != '1);
    assign pop       = (state == S_IDLE) && !empty;
    assign busy      = (count != '0) || (state != S_IDLE);
    assign head_code = eg_code(head);

    eg_fifo #(
        .DEPTH (DEPTH),
        .W     (VAL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (pi_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Value 15 has no codeword; it is dropped and flagged for one cycle.
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= pi_valid && pi_ready && (pi_data == '1);
    end

    // Outputs lag the state by one edge, so a bit appears the cycle after its state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            so_valid <= 1'b0;
            so_data  <= 1'b0;
            n_r      <= '0;
            off_r    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    so_valid <= 1'b0;
                    so_data  <= 1'b0;
                    if (!empty) begin
                        n_r     <= head_code.n;
                        off_r   <= head_code.offset;
                        bit_cnt <= head_code.n - 1'b1;
                        state   <= (head_code.n != '0) ? S_PREFIX : S_SEP;
                    end
                end
                S_PREFIX: begin
                    so_valid <= 1'b1;
                    so_data  <= 1'b1;
                    if (bit_cnt == '0) state <= S_SEP;
                    else               bit_cnt <= bit_cnt - 1'b1;
                end
                S_SEP: begin
                    so_valid <= 1'b1;
                    so_data  <= 1'b0;
                    bit_cnt  <= n_r - 1'b1;
                    gap_cnt  <= '0;
                    if (n_r != '0)   state <= S_OFFSET;
                    else if (GAP > 0) state <= S_GAP;
                    else              state <= S_IDLE;
                end
                S_OFFSET: begin
                    so_valid <= 1'b1;
                    so_data  <= off_r[bit_cnt];
                    gap_cnt  <= '0;
                    if (bit_cnt == '0) state <= (GAP > 0) ? S_GAP : S_IDLE;
                    else               bit_cnt <= bit_cnt - 1'b1;
                end
                S_GAP: begin
                    so_valid <= 1'b0;
                    so_data  <= 1'b0;
                    if (gap_cnt == GW'(GAP - 1)) state <= S_IDLE;
                    else                         gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    so_valid <= 1'b0;
                    so_data  <= 1'b0;
                end
            endcase
        end
    end

endmodule
